eclk_div_bank: RTL and testbench

Parametrised, multi-channel edge-clock divider bank. It generalises a single ECLK primitive to NCH independent channels, each with:
- a programmable integer divide ratio,
- glitch-free ratio reload,
- SLIP phase adjustment,
- a synchronous stop/resume handshake.

A global align strobe phase-aligns all channels. It sits between the edge-clock source and the per-bank gearing logic, and produces registered divided-clock levels and wrap ticks in the clk domain.

---
 rtl/eclk_div_bank.sv | 115 +++++++++++
 tb/tb_eclk_div_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/eclk_div_bank.sv
// eclk_div_bank
//   Multi-channel edge-clock divider bank. Every channel divides clk by its own
//   programmable integer ratio. It also provides glitch-free ratio reload at the
//   wrap point, single-cycle slip phase adjustment, and a stop/resume handshake
//   that only takes effect at the wrap point. A global align strobe restarts all
//   channels in phase.
//
// Ports
//   clk       edge clock, all logic on the rising edge
//   rst_n     synchronous active-low reset
//   align     global phase-align strobe
//   div_sel   ratio for channel i in bits [i*DIV_W +: DIV_W] (values < 2 act as 2)
//   slip      per-channel slip request, holds the phase one cycle per asserted cycle
//   stop_req  per-channel stop request (level)
//   div_out   registered divided-clock level
//   tick      one-cycle pulse on each div_out rising cycle
//   stopped   channel halted with div_out low
//
// Channel mode (per-channel stp_q flag)
//   mode    | meaning
//   run     | counting 0..R-1, div_out high while cnt < R/2
//   stopped | parked at cnt = R-1 with div_out low, waiting for stop_req to drop

module eclk_div_bank #(
    parameter int NCH   = 4,
    parameter int DIV_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 align,
    input  logic [NCH*DIV_W-1:0] div_sel,
    input  logic [NCH-1:0]       slip,
    input  logic [NCH-1:0]       stop_req,
    output logic [NCH-1:0]       div_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       stopped
);

    logic [DIV_W-1:0] cnt_q   [NCH];
    logic [DIV_W-1:0] cnt_d   [NCH];
    logic [DIV_W-1:0] ratio_q [NCH];
    logic [DIV_W-1:0] ratio_d [NCH];
    logic [NCH-1:0]   div_q, div_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   stp_q, stp_d;

    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] x);
        return (x < DIV_W'(2)) ? DIV_W'(2) : x;
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]   = cnt_q[i];
            ratio_d[i] = ratio_q[i];
            div_d[i]   = div_q[i];
            tick_d[i]  = 1'b0;
            stp_d[i]   = stp_q[i];

            if (align) begin
                // Park every channel at its pre-wrap count so all wrap together next edge.
                ratio_d[i] = clamp_ratio(div_sel[i*DIV_W +: DIV_W]);
                cnt_d[i]   = clamp_ratio(div_sel[i*DIV_W +: DIV_W]) - DIV_W'(1);
                div_d[i]   = 1'b0;
            end else if (stp_q[i]) begin
                if (!stop_req[i]) begin
                    // Resume with the wrap that was suppressed when the channel stopped.
                    ratio_d[i] = clamp_ratio(div_sel[i*DIV_W +: DIV_W]);
                    cnt_d[i]   = '0;
                    div_d[i]   = 1'b1;
                    tick_d[i]  = 1'b1;
                    stp_d[i]   = 1'b0;
                end
            end else if (cnt_q[i] == ratio_q[i] - DIV_W'(1)) begin
                if (stop_req[i]) begin
                    // div_out is already low at cnt = R-1, so stopping here is glitch-free.
                    div_d[i] = 1'b0;
                    stp_d[i] = 1'b1;
                end else if (!slip[i]) begin
                    ratio_d[i] = clamp_ratio(div_sel[i*DIV_W +: DIV_W]);
                    cnt_d[i]   = '0;
                    div_d[i]   = 1'b1;
                    tick_d[i]  = 1'b1;
                end
            end else if (!slip[i]) begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
                div_d[i] = (cnt_q[i] + DIV_W'(1)) < (ratio_q[i] >> 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                ratio_q[i] <= clamp_ratio(div_sel[i*DIV_W +: DIV_W]);
                cnt_q[i]   <= clamp_ratio(div_sel[i*DIV_W +: DIV_W]) - DIV_W'(1);
            end
            div_q  <= '0;
            tick_q <= '0;
            stp_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ratio_q[i] <= ratio_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            div_q  <= div_d;
            tick_q <= tick_d;
            stp_q  <= stp_d;
        end
    end

    assign div_out = div_q;
    assign tick    = tick_q;
    assign stopped = stp_q;

endmodule

// File: tb/tb_eclk_div_bank.sv
// Testbench for eclk_div_bank (NCH=4, DIV_W=4).
// Vectors are built into a table up front. Each vector's expected outputs are
// pushed to a scoreboard queue when the vector is driven. They are popped and
// compared once the registered outputs for that edge are visible.

module tb_eclk_div_bank;

    localparam int NCH   = 4;
    localparam int DIV_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 align;
    logic [NCH*DIV_W-1:0] div_sel;
    logic [NCH-1:0]       slip;
    logic [NCH-1:0]       stop_req;
    logic [NCH-1:0]       div_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       stopped;

    eclk_div_bank #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .align    (align),
        .div_sel  (div_sel),
        .slip     (slip),
        .stop_req (stop_req),
        .div_out  (div_out),
        .tick     (tick),
        .stopped  (stopped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        align;
        logic [15:0] sel;
        logic [3:0]  slip;
        logic [3:0]  stop;
        logic [3:0]  e_div;
        logic [3:0]  e_tick;
        logic [3:0]  e_stp;
        logic [3:0]  mask;
        int          scen;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [15:0] SEL_A = 16'hF034;  // ch0=4 ch1=3 ch2=0(->2) ch3=15
    localparam logic [15:0] SEL_B = 16'hF036;  // ch0 changed to 6

    // Ideal free-running waveform for SEL_A, k = edges since reset release (k >= 1).
    // Returns {tick, div}.
    function automatic logic [7:0] ref_pat(input int k);
        logic [3:0] d;
        logic [3:0] t;
        d = '0;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            int r;
            int p;
            case (c)
                0:       r = 4;
                1:       r = 3;
                2:       r = 2;
                default: r = 15;
            endcase
            p    = (k - 1) % r;
            d[c] = (p < r / 2);
            t[c] = (p == 0);
        end
        return {t, d};
    endfunction

    task automatic add(input logic rn, input logic al, input logic [15:0] s,
                       input logic [3:0] sl, input logic [3:0] st,
                       input logic [3:0] ed, input logic [3:0] et, input logic [3:0] es,
                       input logic [3:0] m, input int sc);
        vec_t v;
        v.rst_n = rn; v.align = al; v.sel = s; v.slip = sl; v.stop = st;
        v.e_div = ed; v.e_tick = et; v.e_stp = es; v.mask = m; v.scen = sc;
        vecs.push_back(v);
    endtask

    task automatic check(input vec_t e, input int idx);
        n_tests++;
        if ((((div_out ^ e.e_div) | (tick ^ e.e_tick) | (stopped ^ e.e_stp)) & e.mask) != 4'b0) begin
            n_fail++;
            $display("FAIL s%0d v%0d: got div_out=%b tick=%b stopped=%b, want %b %b %b (mask %b)",
                     e.scen, idx, div_out, tick, stopped, e.e_div, e.e_tick, e.e_stp, e.mask);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] p;
        vec_t       e;

        rst_n    = 1'b0;
        align    = 1'b0;
        div_sel  = SEL_A;
        slip     = '0;
        stop_req = '0;

        // 1: basic waveforms after reset, including clamped ratio on ch2
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1);
        for (int k = 1; k <= 30; k++) begin
            p = ref_pat(k);
            add(1, 0, SEL_A, 4'h0, 4'h0, p[3:0], p[7:4], 4'h0, 4'hF, 1);
        end

        // 2: ch0 ratio 4 -> 6 changed while cnt=1; reload only at the wrap
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 2);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 2);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 2);
        add(1, 0, SEL_B, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 2);

        // 3: ch0 slip for two cycles at cnt=1 stretches the high phase
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 3);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 3);

        // 4: ch1 stop raised at cnt=0; slip at the stop edge loses, slip while stopped ignored
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4);
        add(1, 0, SEL_A, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4);
        add(1, 0, SEL_A, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4);
        add(1, 0, SEL_A, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4);

        // 5: align with mixed phases, slip on ch0 during align is dropped
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 5);
        for (int k = 1; k <= 5; k++) begin
            p = ref_pat(k);
            add(1, 0, SEL_A, 4'h0, 4'h0, p[3:0], p[7:4], 4'h0, 4'hF, 5);
        end
        add(1, 1, SEL_A, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 5);
        for (int k = 1; k <= 6; k++) begin
            p = ref_pat(k);
            add(1, 0, SEL_A, 4'h0, 4'h0, p[3:0], p[7:4], 4'h0, 4'hF, 5);
        end

        // 6: reset while ch0 is stopped and ch3 is mid-high, then clean restart
        add(0, 0, SEL_A, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 6);
        for (int k = 1; k <= 3; k++) begin
            p = ref_pat(k);
            add(1, 0, SEL_A, 4'h0, 4'h1, p[3:0] & 4'hE, p[7:4] & 4'hE, 4'h1, 4'hF, 6);
        end
        add(0, 0, SEL_A, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 6);
        for (int k = 1; k <= 16; k++) begin
            p = ref_pat(k);
            add(1, 0, SEL_A, 4'h0, 4'h0, p[3:0], p[7:4], 4'h0, 4'hF, 6);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n    = vecs[i].rst_n;
            align    = vecs[i].align;
            div_sel  = vecs[i].sel;
            slip     = vecs[i].slip;
            stop_req = vecs[i].stop;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e, i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
